// File: rtl/uart_tx_arbiter.sv
`timescale 1ns / 1ps
// uart_tx_arbiter
// Shares one uart_tx transmitter between NUM_REQ byte requesters with round-robin
// arbitration.
//
// Flow per frame:
// - Latch the winner's byte.
// - Strobe uart_tx_dv_o for one cycle.
// - Wait for uart_tx_done_i, then pulse ack_o for the winner.
// - Wait for done to fall before going idle again.
//
// Optional feature: define UART_ARB_TIMEOUT_EN to add a frame watchdog. It aborts
// WAIT_DONE after TIMEOUT_CYCLES cycles, pulses timeout_err_o and does not ack.
//
// Ports:
//   clk             system clock, posedge
//   rst_n           asynchronous active-low reset
//   req_i           per-requester request, held with data stable until ack
//   req_data_i      byte of requester i on [8*i+7:8*i]
//   ack_o           one-cycle pulse, byte of requester i fully transmitted
//   grant_id_o      index of current/last granted requester
//   busy_o          high from grant until return to idle
//   uart_tx_dv_o    one-cycle start strobe to uart_tx
//   uart_data_o     byte to uart_tx, constant from grant to idle
//   uart_tx_done_i  done from uart_tx, high 2 cycles at end of frame
//   timeout_err_o   one-cycle pulse on watchdog expiry (0 when feature off)
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd2000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]   ack_o,
  output logic [2:0]           grant_id_o,
  output logic                 busy_o,
  output logic                 uart_tx_dv_o,
  output logic [7:0]           uart_data_o,
  input  logic                 uart_tx_done_i,
  output logic                 timeout_err_o
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 16'd2) begin : g_param_check
    $fatal(1, "uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES at least 2");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StWaitDone, StRelease} state_e;

  state_e             state_q, state_d;
  logic [2:0]         rr_ptr_q, rr_ptr_d;
  logic [2:0]         grant_id_q, grant_id_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               busy_q, busy_d;
  logic               tx_dv_q, tx_dv_d;
  logic [7:0]         data_q, data_d;

  // Round-robin search: scan from rr_ptr+1 upward with wrap, first set request wins.
  logic                 found;
  logic [2:0]           winner;
  logic [7:0]           win_data;
  int unsigned          idx;
  logic [NUM_REQ-1:0]   req_shift;
  logic [8*NUM_REQ-1:0] data_shift;

  always_comb begin
    found      = 1'b0;
    winner     = '0;
    win_data   = '0;
    idx        = '0;
    req_shift  = '0;
    data_shift = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx        = ({29'd0, rr_ptr_q} + off) % NUM_REQ;
      req_shift  = req_i >> idx;
      data_shift = req_data_i >> (8 * idx);
      if (!found && req_shift[0]) begin
        found    = 1'b1;
        winner   = idx[2:0];
        win_data = data_shift[7:0];
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
`endif

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    ack_d      = '0;
    busy_d     = busy_q;
    tx_dv_d    = 1'b0;
    data_d     = data_q;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    timeout_d  = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        // A done still high belongs to a previous frame; wait for it to fall.
        if (found && !uart_tx_done_i) begin
          grant_id_d = winner;
          rr_ptr_d   = winner;
          data_d     = win_data;
          tx_dv_d    = 1'b1;
          busy_d     = 1'b1;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        // Done is deliberately not sampled here.
        state_d = StWaitDone;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      StWaitDone: begin
        if (uart_tx_done_i) begin
          ack_d   = NUM_REQ'(1) << grant_id_q;
          state_d = StRelease;
`ifdef UART_ARB_TIMEOUT_EN
        end else if (cnt_q == TIMEOUT_CYCLES - 16'd1) begin
          // rr_ptr stays on the winner so it retries only after the others.
          timeout_d = 1'b1;
          state_d   = StRelease;
        end else begin
          cnt_d = cnt_q + 16'd1;
`endif
        end
      end
      StRelease: begin
        if (!uart_tx_done_i) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rr_ptr_q   <= 3'(NUM_REQ - 1);
      grant_id_q <= '0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
      tx_dv_q    <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      tx_dv_q    <= tx_dv_d;
      data_q     <= data_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_err_o = timeout_q;
`else
  assign timeout_err_o = 1'b0;
`endif

  assign ack_o        = ack_q;
  assign grant_id_o   = grant_id_q;
  assign busy_o       = busy_q;
  assign uart_tx_dv_o = tx_dv_q;
  assign uart_data_o  = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns / 1ps
// Self-checking bench for uart_tx_arbiter (NUM_REQ=4): a cycle-by-cycle vector
// table plus hand-written sequences for rotation, reset abort, stale done and
// (when UART_ARB_TIMEOUT_EN is defined) the watchdog.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [2:0]  grant_id;
  logic        busy;
  logic        tx_dv;
  logic [7:0]  uart_data;
  logic        tx_done;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;

  uart_tx_arbiter #(
    .NUM_REQ        (4),
    .TIMEOUT_CYCLES (16'd50)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_i          (req),
    .req_data_i     (req_data),
    .ack_o          (ack),
    .grant_id_o     (grant_id),
    .busy_o         (busy),
    .uart_tx_dv_o   (tx_dv),
    .uart_data_o    (uart_data),
    .uart_tx_done_i (tx_done),
    .timeout_err_o  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic        done;
    logic [3:0]  ack;
    logic [2:0]  gid;
    logic        busy;
    logic        dv;
    logic [7:0]  udata;
  } vec_t;

  vec_t vecs[31];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Packed view of all outputs: {timeout_err, ack, grant_id, busy, dv, data}.
  function automatic logic [31:0] outs();
    return {14'd0, timeout_err, ack, grant_id, busy, tx_dv, uart_data};
  endfunction

  function automatic logic [31:0] pack(logic te, logic [3:0] a, logic [2:0] g, logic b,
                                       logic d, logic [7:0] u);
    return {14'd0, te, a, g, b, d, u};
  endfunction

  task automatic do_reset(input logic done_val);
    @(negedge clk);
    rst_n   = 1'b0;
    req     = '0;
    tx_done = done_val;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at the negedge after a grant (FSM in ISSUE): 2-cycle done, then idle.
  task automatic finish_frame();
    tx_done = 1'b1;
    repeat (2) @(negedge clk);
    req     = '0;
    tx_done = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int         ack_cnt;
    logic [3:0] ack_seen;
    int         c;

    rst_n    = 1'b0;
    req      = '0;
    req_data = '0;
    tx_done  = 1'b0;

    // req, data, done | ack, gid, busy, dv, uart_data
    vecs[0]  = '{4'b0100, 32'h00A5_0000, 1'b0, 4'b0000, 3'd2, 1'b1, 1'b1, 8'hA5};
    vecs[1]  = '{4'b0100, 32'h00A5_0000, 1'b0, 4'b0000, 3'd2, 1'b1, 1'b0, 8'hA5};
    vecs[2]  = '{4'b0100, 32'h00A5_0000, 1'b0, 4'b0000, 3'd2, 1'b1, 1'b0, 8'hA5};
    vecs[3]  = '{4'b0100, 32'h00A5_0000, 1'b1, 4'b0100, 3'd2, 1'b1, 1'b0, 8'hA5};
    vecs[4]  = '{4'b0000, 32'h00A5_0000, 1'b1, 4'b0000, 3'd2, 1'b1, 1'b0, 8'hA5};
    vecs[5]  = '{4'b0000, 32'h00A5_0000, 1'b0, 4'b0000, 3'd2, 1'b0, 1'b0, 8'hA5};
    vecs[6]  = '{4'b0000, 32'h00A5_0000, 1'b0, 4'b0000, 3'd2, 1'b0, 1'b0, 8'hA5};
    // Data captured at grant; the change to 22 only shows in the next frame.
    vecs[7]  = '{4'b0010, 32'h0000_1100, 1'b0, 4'b0000, 3'd1, 1'b1, 1'b1, 8'h11};
    vecs[8]  = '{4'b0010, 32'h0000_2200, 1'b0, 4'b0000, 3'd1, 1'b1, 1'b0, 8'h11};
    vecs[9]  = '{4'b0010, 32'h0000_2200, 1'b1, 4'b0010, 3'd1, 1'b1, 1'b0, 8'h11};
    vecs[10] = '{4'b0010, 32'h0000_2200, 1'b1, 4'b0000, 3'd1, 1'b1, 1'b0, 8'h11};
    vecs[11] = '{4'b0010, 32'h0000_2200, 1'b0, 4'b0000, 3'd1, 1'b0, 1'b0, 8'h11};
    vecs[12] = '{4'b0010, 32'h0000_2200, 1'b0, 4'b0000, 3'd1, 1'b1, 1'b1, 8'h22};
    vecs[13] = '{4'b0010, 32'h0000_2200, 1'b0, 4'b0000, 3'd1, 1'b1, 1'b0, 8'h22};
    vecs[14] = '{4'b0010, 32'h0000_2200, 1'b1, 4'b0010, 3'd1, 1'b1, 1'b0, 8'h22};
    vecs[15] = '{4'b0000, 32'h0000_2200, 1'b1, 4'b0000, 3'd1, 1'b1, 1'b0, 8'h22};
    vecs[16] = '{4'b0000, 32'h0000_2200, 1'b0, 4'b0000, 3'd1, 1'b0, 1'b0, 8'h22};
    // Done during ISSUE is ignored; ack only once done is seen in WAIT_DONE.
    vecs[17] = '{4'b1000, 32'h3C00_0000, 1'b0, 4'b0000, 3'd3, 1'b1, 1'b1, 8'h3C};
    vecs[18] = '{4'b1000, 32'h3C00_0000, 1'b1, 4'b0000, 3'd3, 1'b1, 1'b0, 8'h3C};
    vecs[19] = '{4'b1000, 32'h3C00_0000, 1'b0, 4'b0000, 3'd3, 1'b1, 1'b0, 8'h3C};
    vecs[20] = '{4'b1000, 32'h3C00_0000, 1'b1, 4'b1000, 3'd3, 1'b1, 1'b0, 8'h3C};
    vecs[21] = '{4'b1001, 32'h3C00_005A, 1'b0, 4'b0000, 3'd3, 1'b0, 1'b0, 8'h3C};
    // Wrap: after winner 3, requester 0 has priority; then 3 again before 0.
    vecs[22] = '{4'b1001, 32'h3C00_005A, 1'b0, 4'b0000, 3'd0, 1'b1, 1'b1, 8'h5A};
    vecs[23] = '{4'b1001, 32'h3C00_005A, 1'b0, 4'b0000, 3'd0, 1'b1, 1'b0, 8'h5A};
    vecs[24] = '{4'b1001, 32'h3C00_005A, 1'b1, 4'b0001, 3'd0, 1'b1, 1'b0, 8'h5A};
    vecs[25] = '{4'b1001, 32'h3C00_005A, 1'b1, 4'b0000, 3'd0, 1'b1, 1'b0, 8'h5A};
    vecs[26] = '{4'b1001, 32'h3C00_005A, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0, 8'h5A};
    vecs[27] = '{4'b1001, 32'h3C00_005A, 1'b0, 4'b0000, 3'd3, 1'b1, 1'b1, 8'h3C};
    vecs[28] = '{4'b1001, 32'h3C00_005A, 1'b0, 4'b0000, 3'd3, 1'b1, 1'b0, 8'h3C};
    vecs[29] = '{4'b1001, 32'h3C00_005A, 1'b1, 4'b1000, 3'd3, 1'b1, 1'b0, 8'h3C};
    vecs[30] = '{4'b0000, 32'h3C00_005A, 1'b0, 4'b0000, 3'd3, 1'b0, 1'b0, 8'h3C};

    do_reset(1'b0);
    check("reset_values", outs(), 32'd0);

    for (int i = 0; i < 31; i++) begin
      req      = vecs[i].req;
      req_data = vecs[i].data;
      tx_done  = vecs[i].done;
      @(negedge clk);
      check($sformatf("vec%0d", i), outs(),
            pack(1'b0, vecs[i].ack, vecs[i].gid, vecs[i].busy, vecs[i].dv, vecs[i].udata));
    end

    // All four held: grants rotate 0,1,2,3,0 with exactly one ack per frame.
    req      = 4'b1111;
    req_data = 32'h4433_2211;
    for (int f = 0; f < 5; f++) begin
      c = 0;
      while (!tx_dv && c < 20) begin
        @(negedge clk);
        c++;
      end
      check($sformatf("rr_grant%0d", f), {28'd0, tx_dv, grant_id},
            {28'd0, 1'b1, 3'(f % 4)});
      ack_cnt  = 0;
      ack_seen = '0;
      tx_done  = 1'b1;
      repeat (2) begin
        @(negedge clk);
        if (ack != 4'b0000) begin
          ack_cnt++;
          ack_seen |= ack;
        end
      end
      if (f == 4) req = '0;
      tx_done = 1'b0;
      @(negedge clk);
      if (ack != 4'b0000) begin
        ack_cnt++;
        ack_seen |= ack;
      end
      check($sformatf("rr_ack%0d", f), {ack_cnt[27:0], ack_seen},
            {28'd1, 4'b0001 << (f % 4)});
    end

    // Reset during WAIT_DONE: async return to reset values, no ack, rr pointer reset.
    req = 4'b0011;
    @(negedge clk);
    check("abort_grant", {28'd0, tx_dv, grant_id}, {28'd0, 1'b1, 3'd1});
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("abort_async_reset", outs(), 32'd0);
    tx_done = 1'b1;
    @(negedge clk);
    check("abort_no_ack", outs(), 32'd0);
    rst_n   = 1'b1;
    tx_done = 1'b0;
    @(negedge clk);
    check("after_reset_grant", outs(), pack(1'b0, 4'b0000, 3'd0, 1'b1, 1'b1, 8'h11));
    finish_frame();

    // Stale done at reset exit blocks any grant until it falls.
    do_reset(1'b1);
    req = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("stale_done%0d", k), {30'd0, tx_dv, busy}, 32'd0);
    end
    tx_done = 1'b0;
    @(negedge clk);
    check("stale_done_grant", outs(), pack(1'b0, 4'b0000, 3'd3, 1'b1, 1'b1, 8'h44));
    finish_frame();

`ifdef UART_ARB_TIMEOUT_EN
    // Done never arrives: pulse on the 50th WAIT_DONE cycle, no ack, back to idle.
    req = 4'b0001;
    @(negedge clk);
    check("wd_grant", {28'd0, tx_dv, grant_id}, {28'd0, 1'b1, 3'd0});
    req = '0;
    for (int k = 1; k <= 51; k++) begin
      @(negedge clk);
      if (k == 50) check("wd_not_yet", {31'd0, timeout_err}, 32'd0);
      if (k == 51) check("wd_pulse", {27'd0, timeout_err, ack}, {27'd0, 1'b1, 4'b0000});
    end
    @(negedge clk);
    check("wd_idle", {30'd0, timeout_err, busy}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
